// File: rtl/fx2_result_pipe_pkg.sv
// Shared constants and instruction-ID encodings for the FX2 result pipeline.
package fx2_result_pipe_pkg;

  localparam int FX2_LATENCY = 4;
  localparam int FX2_DATA_W  = 128;
  localparam int FX2_ADDR_W  = 7;
  localparam int FX2_ID_W    = 7;

  typedef enum logic [0:FX2_ID_W-1] {
    ID_NOP    = 7'd0,
    ID_SHLQBI = 7'd40,
    ID_ROTQBI = 7'd41,
    ID_SHLQBY = 7'd42,
    ID_ROTQBY = 7'd43
  } fx2_instr_id_e;

  // Low bit index of a stage's slice in a flattened tap bus (stage 0 first).
  function automatic int unsigned fx2_slice_lo(input int unsigned stage, input int unsigned w);
    return stage * w;
  endfunction

endpackage

// File: rtl/fx2_result_pipe_if.sv
// Issue, control, writeback and forwarding signals of the FX2 result pipeline.
interface fx2_result_pipe_if #(
  parameter int LATENCY = 4,
  parameter int DATA_W  = 128,
  parameter int ADDR_W  = 7,
  parameter int ID_W    = 7
);
  logic                       in_valid;
  logic [0:ID_W-1]            in_instr_id;
  logic [0:ADDR_W-1]          in_rt_addr;
  logic [0:DATA_W-1]          in_result;
  logic                       stall;
  logic                       flush;
  logic                       wb_valid;
  logic [0:ADDR_W-1]          wb_rt_addr;
  logic [0:DATA_W-1]          wb_data;
  logic [0:ID_W-1]            wb_instr_id;
  logic [0:LATENCY-1]         fwd_valid;
  logic [0:LATENCY*ADDR_W-1]  fwd_rt_addr;
  logic [0:LATENCY*DATA_W-1]  fwd_data;
  logic                       busy;

  modport master (
    output in_valid, in_instr_id, in_rt_addr, in_result, stall, flush,
    input  wb_valid, wb_rt_addr, wb_data, wb_instr_id,
    input  fwd_valid, fwd_rt_addr, fwd_data, busy
  );

  modport slave (
    input  in_valid, in_instr_id, in_rt_addr, in_result, stall, flush,
    output wb_valid, wb_rt_addr, wb_data, wb_instr_id,
    output fwd_valid, fwd_rt_addr, fwd_data, busy
  );
endinterface

// File: rtl/fx2_result_pipe_stage.sv
// One FX2 result stage: valid bit plus payload, with hold (stall) and kill (flush).
module fx2_pipe_stage #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold_i,
  input  logic         kill_i,
  input  logic         vld_i,
  input  logic [0:W-1] d_i,
  output logic         vld_o,
  output logic [0:W-1] q_o
);

  logic         vld_q, vld_d;
  logic [0:W-1] dat_q, dat_d;

  // Kill wins over hold; payload simply follows hold since valid gates its use.
  always_comb begin
    vld_d = vld_i;
    dat_d = d_i;
    if (kill_i)      vld_d = 1'b0;
    else if (hold_i) vld_d = vld_q;
    if (hold_i)      dat_d = dat_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      dat_q <= '0;
    end else begin
      vld_q <= vld_d;
      dat_q <= dat_d;
    end
  end

  assign vld_o = vld_q;
  assign q_o   = dat_q;

endmodule

// File: rtl/fx2_result_pipe.sv
// FX2 result delay line: LATENCY stages from ALU to register-file write port.
// Forwarding taps are driven only when FX2_FWD_EN is defined; otherwise tied to 0.
module fx2_result_pipe
  import fx2_result_pipe_pkg::*;
#(
  parameter int LATENCY = FX2_LATENCY,
  parameter int DATA_W  = FX2_DATA_W,
  parameter int ADDR_W  = FX2_ADDR_W,
  parameter int ID_W    = FX2_ID_W
) (
  input  logic             clk,
  input  logic             rst_n,
  fx2_result_pipe_if.slave bus
);

  localparam int EW = ID_W + ADDR_W + DATA_W;

  logic [0:LATENCY-1] vld;
  logic [0:LATENCY-1] vld_src;
  logic [0:EW-1]      ent     [LATENCY];
  logic [0:EW-1]      ent_src [LATENCY];
  logic [0:EW-1]      in_ent;

  // Entry layout, MSB first: {instr_id, rt_addr, data}.
  assign in_ent = {bus.in_instr_id, bus.in_rt_addr, bus.in_result};

  for (genvar k = 0; k < LATENCY; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign vld_src[k] = bus.in_valid;
      assign ent_src[k] = in_ent;
    end else begin : g_body
      assign vld_src[k] = vld[k-1];
      assign ent_src[k] = ent[k-1];
    end

    fx2_pipe_stage #(.W(EW)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (bus.stall),
      .kill_i (bus.flush),
      .vld_i  (vld_src[k]),
      .d_i    (ent_src[k]),
      .vld_o  (vld[k]),
      .q_o    (ent[k])
    );
  end

  // A stalled tail entry is written on the cycle the stall releases, never twice.
  assign bus.wb_valid = vld[LATENCY-1] & ~bus.stall;
  assign {bus.wb_instr_id, bus.wb_rt_addr, bus.wb_data} = ent[LATENCY-1];
  assign bus.busy = |vld;

`ifdef FX2_FWD_EN
  for (genvar k = 0; k < LATENCY; k++) begin : g_fwd
    assign bus.fwd_valid[k] = vld[k];
    assign bus.fwd_rt_addr[fx2_slice_lo(k, ADDR_W) +: ADDR_W] = ent[k][ID_W +: ADDR_W];
    assign bus.fwd_data[fx2_slice_lo(k, DATA_W) +: DATA_W]    = ent[k][ID_W+ADDR_W +: DATA_W];
  end
`else
  assign bus.fwd_valid   = '0;
  assign bus.fwd_rt_addr = '0;
  assign bus.fwd_data    = '0;
`endif

endmodule

// File: tb/tb_fx2_result_pipe.sv
// Directed and random bench for fx2_result_pipe against an age-tracking op-list model.
module tb_fx2_result_pipe;

  localparam int L  = 4;
  localparam int DW = 128;
  localparam int AW = 7;
  localparam int IW = 7;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fx2_result_pipe_if #(.LATENCY(L), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) bus ();

  fx2_result_pipe #(.LATENCY(L), .DATA_W(DW), .ADDR_W(AW), .ID_W(IW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Each in-flight op remembers how many advancing edges it has seen.
  typedef struct {
    logic [IW-1:0] id;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            age;
  } op_t;

  op_t mq[$];
  int  ncmp = 0;
  int  nerr = 0;
  int  cyc, first_wb, wbcnt;
  logic [AW-1:0] last_wb_addr;

  task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [0:L-1]    ev = '0;
    logic [0:L*AW-1] ea = '0;
    logic [0:L*AW-1] ma = '0;
    logic [0:L*DW-1] ed = '0;
    logic [0:L*DW-1] md = '0;
    int w = -1;
    foreach (mq[i]) begin
      int a;
      a = mq[i].age;
      ev[a-1] = 1'b1;
      ea[(a-1)*AW +: AW] = mq[i].addr;
      ma[(a-1)*AW +: AW] = '1;
      ed[(a-1)*DW +: DW] = mq[i].data;
      md[(a-1)*DW +: DW] = '1;
      if (a == L) w = i;
    end
    chk("wb_valid", bus.wb_valid, (w >= 0) && !bus.stall);
    if (w >= 0) begin
      chk("wb_rt_addr", bus.wb_rt_addr, mq[w].addr);
      chk("wb_data", bus.wb_data, mq[w].data);
      chk("wb_instr_id", bus.wb_instr_id, mq[w].id);
    end
    chk("busy", bus.busy, mq.size() != 0);
`ifdef FX2_FWD_EN
    chk("fwd_valid", bus.fwd_valid, ev);
    chk("fwd_rt_addr", bus.fwd_rt_addr & ma, ea);
    chk("fwd_data", bus.fwd_data & md, ed);
`else
    chk("fwd_valid_off", bus.fwd_valid, 0);
    chk("fwd_rt_addr_off", bus.fwd_rt_addr, 0);
    chk("fwd_data_off", bus.fwd_data, 0);
`endif
    if (bus.wb_valid === 1'b1) begin
      wbcnt++;
      last_wb_addr = bus.wb_rt_addr;
      if (first_wb < 0) first_wb = cyc;
    end
  endtask

  task automatic model_edge(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [IW-1:0] id, input logic st, input logic fl);
    op_t n;
    if (fl) begin
      mq.delete();
    end else if (!st) begin
      for (int i = mq.size() - 1; i >= 0; i--)
        if (mq[i].age == L) mq.delete(i);
      foreach (mq[i]) mq[i].age++;
      if (v) begin
        n.id = id; n.addr = a; n.data = d; n.age = 1;
        mq.push_back(n);
      end
    end
  endtask

  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic [IW-1:0] id, input logic st, input logic fl);
    bus.in_valid    = v;
    bus.in_rt_addr  = a;
    bus.in_result   = d;
    bus.in_instr_id = id;
    bus.stall       = st;
    bus.flush       = fl;
    @(negedge clk);
    check_outputs();
    cyc++;
    @(posedge clk);
    model_edge(v, a, d, id, st, fl);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic restart_counts();
    cyc = 0; first_wb = -1; wbcnt = 0; last_wb_addr = '0;
  endtask

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    rst_n = 1'b0;
    bus.in_valid = 1'b0; bus.in_rt_addr = '0; bus.in_result = '0;
    bus.in_instr_id = '0; bus.stall = 1'b0; bus.flush = 1'b0;
    restart_counts();
    #1;
    chk("rst_wb_valid", bus.wb_valid, 0);
    chk("rst_wb_rt_addr", bus.wb_rt_addr, 0);
    chk("rst_wb_data", bus.wb_data, 0);
    chk("rst_wb_instr_id", bus.wb_instr_id, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_fwd_valid", bus.fwd_valid, 0);
    chk("rst_fwd_data", bus.fwd_data, 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Single op
    restart_counts();
    step(1'b1, 7'd5, {16{8'hA5}}, 7'd40, 1'b0, 1'b0);
    idle(6);
    chk("single_latency", first_wb, 4);
    chk("single_count", wbcnt, 1);
    chk("single_addr", last_wb_addr, 5);

    // Back-to-back
    restart_counts();
    step(1'b1, 7'd1, rnd_data(), 7'd41, 1'b0, 1'b0);
    step(1'b1, 7'd2, rnd_data(), 7'd42, 1'b0, 1'b0);
    step(1'b1, 7'd3, rnd_data(), 7'd43, 1'b0, 1'b0);
    idle(6);
    chk("b2b_first", first_wb, 4);
    chk("b2b_count", wbcnt, 3);
    chk("b2b_last_addr", last_wb_addr, 3);

    // Stall while the op sits in the last stage
    restart_counts();
    step(1'b1, 7'd9, rnd_data(), 7'd40, 1'b0, 1'b0);
    idle(3);
    repeat (3) step(1'b0, '0, '0, '0, 1'b1, 1'b0);
    idle(3);
    chk("stall_count", wbcnt, 1);
    chk("stall_release_cycle", first_wb, 7);

    // Flush with ops in all stages and a new op arriving
    restart_counts();
    for (int i = 0; i < 4; i++) step(1'b1, AW'(10 + i), rnd_data(), 7'd41, 1'b0, 1'b0);
    step(1'b1, 7'd20, rnd_data(), 7'd42, 1'b0, 1'b1);
    idle(6);
    chk("flush_count", wbcnt, 1);
    chk("flush_commit_cycle", first_wb, 4);
    chk("flush_commit_addr", last_wb_addr, 10);

    // Asynchronous reset with four ops in flight
    restart_counts();
    for (int i = 0; i < 4; i++) step(1'b1, AW'(30 + i), rnd_data(), 7'd43, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_wb_valid", bus.wb_valid, 0);
    chk("arst_wb_rt_addr", bus.wb_rt_addr, 0);
    chk("arst_wb_data", bus.wb_data, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_fwd_valid", bus.fwd_valid, 0);
    mq.delete();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(6);
    chk("arst_no_stale_wb", wbcnt, 0);

    // Random traffic with stalls and flushes
    restart_counts();
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 9) < 7), AW'($urandom), rnd_data(), IW'($urandom),
           ($urandom_range(0, 9) < 2), ($urandom_range(0, 19) == 0));
    end
    idle(L + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
